md_scheduler: RTL and testbench

//   Multiply/divide unit controller for the 5-stage MIPS pipeline. Accepts

---
 rtl/md_scheduler.sv | 160 ++++++++++++++++
 tb/tb_md_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide controller for the MIPS pipeline: owns HI/LO, models MULT/DIV latency
// and requests a stall for D-stage MD-class instructions while an operation is in flight.
module md_scheduler #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             d_is_md,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state  | meaning
    // S_IDLE | no operation in flight; MTHI/MTLO accepted, start accepted
    // S_RUN  | result held in shadow regs, counting down to the HI/LO commit
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_shadow_hi;
    logic [WIDTH-1:0]   r_shadow_lo;
    logic               r_commit;

    logic               w_accept;
    logic               w_last;
    logic               w_is_div;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_den;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic signed [WIDTH-1:0]   w_quo_s;
    logic signed [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_quo_u;
    logic [WIDTH-1:0]   w_rem_u;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic [WIDTH-1:0]   w_min_neg;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_count == CW'(1));
    assign w_is_div  = md_op[1];
    assign w_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    // Divisor is forced to 1 for zero and signed-overflow cases so the
    // divider never sees an undefined operation; those results are patched below.
    assign w_div_zero = (rt_val == '0);
    assign w_div_ovf  = !md_op[0] && (rs_val == w_min_neg) && (rt_val == '1);
    assign w_den      = (w_div_zero || w_div_ovf) ? WIDTH'(1) : rt_val;

    assign w_prod_s = $signed({{WIDTH{rs_val[WIDTH-1]}}, rs_val})
                    * $signed({{WIDTH{rt_val[WIDTH-1]}}, rt_val});
    assign w_prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
    assign w_quo_s  = $signed(rs_val) / $signed(w_den);
    assign w_rem_s  = $signed(rs_val) % $signed(w_den);
    assign w_quo_u  = rs_val / w_den;
    assign w_rem_u  = rs_val % w_den;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        case (md_op)
            2'b00: begin
                w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_s[WIDTH-1:0];
            end
            2'b01: begin
                w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_u[WIDTH-1:0];
            end
            2'b10: begin
                if (w_div_ovf) begin
                    w_res_hi = '0;
                    w_res_lo = w_min_neg;
                end else begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quo_s;
                end
            end
            default: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == S_RUN);
        stall = d_is_md & (start | busy);
        hi    = r_hi;
        lo    = r_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_shadow_hi <= '0;
            r_shadow_lo <= '0;
            r_commit    <= 1'b0;
        end else if (w_accept) begin
            r_shadow_hi <= w_res_hi;
            r_shadow_lo <= w_res_lo;
            r_commit    <= !(w_is_div && w_div_zero);
            r_count     <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                r_count <= '0;
                if (r_commit) begin
                    r_hi <= r_shadow_hi;
                    r_lo <= r_shadow_lo;
                end
            end else begin
                r_count <= r_count - CW'(1);
            end
        end else begin
            // Zero-latency MTHI/MTLO; a start in the same cycle takes the branch above.
            if (hi_we) r_hi <= rs_val;
            if (lo_we) r_lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: latency, HI/LO results, stall, MTHI/MTLO and async reset.
module tb_md_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_scheduler #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .d_is_md(d_is_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op on the next rising edge, then count busy cycles (sampled at negedges).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic with_lo_we, output int n);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; lo_we = with_lo_we;
        @(posedge clk);
        #1;
        start = 1'b0; lo_we = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
    endtask

    task automatic check_op(input string name, input int n, input int exp_n,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, n, exp_n);
        end
        checks++;
        if (hi !== exp_hi) begin
            errors++;
            $display("FAIL %s hi got %h expected %h", name, hi, exp_hi);
        end
        checks++;
        if (lo !== exp_lo) begin
            errors++;
            $display("FAIL %s lo got %h expected %h", name, lo, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = 2'b00; rs_val = '0; rt_val = '0;
        hi_we = 1'b0; lo_we = 1'b0; d_is_md = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", stall); end
        checks++;
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h expected 0", hi); end
        checks++;
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h expected 0", lo); end
        d_is_md = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        run_op(2'b00, 32'hFFFFFFFE, 32'h3, 1'b0, n);
        check_op("mult_neg", n, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n);
        check_op("multu_max", n, 5, 32'hFFFFFFFE, 32'h00000001);
    endtask

    task automatic test_div();
        int n;
        run_op(2'b10, 32'hFFFFFFF9, 32'h2, 1'b0, n);
        check_op("div_neg", n, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
        check_op("div_ovf", n, 10, 32'h00000000, 32'h80000000);
        run_op(2'b11, 32'h7, 32'h0, 1'b0, n);
        check_op("divu_zero", n, 10, 32'h00000000, 32'h80000000);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, n);
        check_op("divu_100_7", n, 10, 32'h2, 32'hE);
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        d_is_md = 1'b1; start = 1'b1; md_op = 2'b00; rs_val = 32'd4; rt_val = 32'd5;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL stall_start_cycle got %b expected 1", stall); end
        @(posedge clk);
        #1;
        start = 1'b0; rs_val = 32'd9; rt_val = 32'd9;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy_cycle%0d got %b expected 1", n, stall); end
            if (n == 2) begin
                start = 1'b1; md_op = 2'b10; rs_val = 32'd100; rt_val = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1;
            end else if (n == 3) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL stall_after_busy got %b expected 0", stall); end
        check_op("mult_ignore_busy_start", n, 5, 32'h0, 32'd20);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got %b expected 0", busy); end
        d_is_md = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        int n;
        @(negedge clk);
        hi_we = 1'b1; rs_val = 32'h12345678;
        @(posedge clk);
        #1;
        hi_we = 1'b0; rs_val = 32'h0;
        checks++;
        if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h expected 12345678", hi); end
        @(negedge clk);
        lo_we = 1'b1; rs_val = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        lo_we = 1'b0; rs_val = 32'h0;
        checks++;
        if (lo !== 32'hCAFEBABE) begin errors++; $display("FAIL mtlo got %h expected cafebabe", lo); end
        checks++;
        if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi_kept got %h expected 12345678", hi); end
        run_op(2'b01, 32'h00010001, 32'h00030000, 1'b1, n);
        check_op("start_beats_lo_we", n, 5, 32'h3, 32'h00030000);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        start = 1'b1; md_op = 2'b10; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b expected 0", busy); end
        checks++;
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_mid_hi got %h expected 0", hi); end
        checks++;
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_mid_lo got %h expected 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        check_op("reset_no_late_write", n, 0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mthi_mtlo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
